// File: rtl/mmio_timer_uart.sv
// Memory-mapped peripheral: reload timer with interrupt, LED/7-segment/switch
// registers and an 8N1 UART transmitter, answering loads combinationally.
module mmio_timer_uart #(
   parameter int          BAUD_DIV = 5208,
   parameter logic [31:0] BASE     = 32'h40000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [7:0]  led,
   input  logic [7:0]  switch,
   output logic [11:0] digi,
   output logic        irq,
   output logic        uart_tx
);

   localparam int             CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CW-1:0]  BAUD_LAST = CW'(BAUD_DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } txState_e;

   logic          hit;
   logic [2:0]    regOff;
   logic          wrHit;
   logic          unusedAddrBits;

   logic [31:0]   th_q, th_d;
   logic [31:0]   tl_q, tl_d;
   logic          timEn_q, timEn_d;
   logic          irqEn_q, irqEn_d;
   logic          irqStatus_q, irqStatus_d;
   logic          irq_q, irq_d;
   logic          ovfSet;
   logic [7:0]    led_q, led_d;
   logic [11:0]   digi_q, digi_d;

   txState_e      state_q, state_d;
   logic [7:0]    txd_q, txd_d;
   logic [CW-1:0] baud_q, baud_d;
   logic [2:0]    bitIdx_q, bitIdx_d;
   logic          txDone_q, txDone_d;
   logic          uartTx_q, uartTx_d;
   logic          txBusy;
   logic          baudEnd;

   assign hit            = (addr[31:5] == BASE[31:5]);
   assign regOff         = addr[4:2];
   assign wrHit          = wr & hit;
   assign unusedAddrBits = ^addr[1:0];
   assign txBusy         = (state_q != IDLE);
   assign baudEnd        = (baud_q == BAUD_LAST);

   // Timer and simple registers; a bus write lands after the hardware update so it wins.
   always_comb begin
      th_d        = th_q;
      tl_d        = tl_q;
      timEn_d     = timEn_q;
      irqEn_d     = irqEn_q;
      led_d       = led_q;
      digi_d      = digi_q;
      ovfSet      = 1'b0;
      if (timEn_q) begin
         if (tl_q == 32'hFFFFFFFF) begin
            tl_d   = th_q;
            ovfSet = irqEn_q;
         end else begin
            tl_d = tl_q + 32'd1;
         end
      end
      irqStatus_d = irqStatus_q | ovfSet;
      if (wrHit) begin
         case (regOff)
            3'd0: th_d = wdata;
            3'd1: tl_d = wdata;
            3'd2: begin
               timEn_d = wdata[0];
               irqEn_d = wdata[1];
               if (!wdata[2]) begin
                  irqStatus_d = 1'b0;
               end
            end
            3'd3: led_d  = wdata[7:0];
            3'd5: digi_d = wdata[11:0];
            default: ;
         endcase
      end
      irq_d = irqEn_d & irqStatus_d;
   end

   // UART transmitter; the done clear is applied first so a frame completion in the same cycle wins.
   always_comb begin
      state_d  = state_q;
      txd_d    = txd_q;
      baud_d   = baud_q;
      bitIdx_d = bitIdx_q;
      txDone_d = txDone_q;
      if (wrHit && (regOff == 3'd7) && wdata[1]) begin
         txDone_d = 1'b0;
      end
      case (state_q)
         IDLE: begin
            if (wrHit && (regOff == 3'd6)) begin
               txd_d    = wdata[7:0];
               state_d  = START;
               baud_d   = '0;
               bitIdx_d = 3'd0;
            end
         end
         START: begin
            if (baudEnd) begin
               baud_d  = '0;
               state_d = DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         DATA: begin
            if (baudEnd) begin
               baud_d   = '0;
               bitIdx_d = bitIdx_q + 3'd1;
               if (bitIdx_q == 3'd7) begin
                  state_d = STOP;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         STOP: begin
            if (baudEnd) begin
               baud_d   = '0;
               state_d  = IDLE;
               txDone_d = 1'b1;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      case (state_d)
         START:   uartTx_d = 1'b0;
         DATA:    uartTx_d = txd_d[bitIdx_d];
         default: uartTx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         th_q        <= '0;
         tl_q        <= '0;
         timEn_q     <= 1'b0;
         irqEn_q     <= 1'b0;
         irqStatus_q <= 1'b0;
         irq_q       <= 1'b0;
         led_q       <= '0;
         digi_q      <= '0;
         state_q     <= IDLE;
         txd_q       <= '0;
         baud_q      <= '0;
         bitIdx_q    <= '0;
         txDone_q    <= 1'b0;
         uartTx_q    <= 1'b1;
      end else begin
         th_q        <= th_d;
         tl_q        <= tl_d;
         timEn_q     <= timEn_d;
         irqEn_q     <= irqEn_d;
         irqStatus_q <= irqStatus_d;
         irq_q       <= irq_d;
         led_q       <= led_d;
         digi_q      <= digi_d;
         state_q     <= state_d;
         txd_q       <= txd_d;
         baud_q      <= baud_d;
         bitIdx_q    <= bitIdx_d;
         txDone_q    <= txDone_d;
         uartTx_q    <= uartTx_d;
      end
   end

   always_comb begin
      rdata = '0;
      if (rd && hit) begin
         case (regOff)
            3'd0:    rdata = th_q;
            3'd1:    rdata = tl_q;
            3'd2:    rdata = {29'd0, irqStatus_q, irqEn_q, timEn_q};
            3'd3:    rdata = {24'd0, led_q};
            3'd4:    rdata = {24'd0, switch};
            3'd5:    rdata = {20'd0, digi_q};
            3'd6:    rdata = {24'd0, txd_q};
            3'd7:    rdata = {30'd0, txDone_q, txBusy};
            default: rdata = '0;
         endcase
      end
   end

   assign led     = led_q;
   assign digi    = digi_q;
   assign irq     = irq_q;
   assign uart_tx = uartTx_q;

endmodule

// File: tb/tb_mmio_timer_uart.sv
// Bench for mmio_timer_uart: directed scenarios with literal expectations plus
// random bus traffic checked every cycle against a register/frame-level model.
module tb_mmio_timer_uart;

   localparam int          BD   = 4;
   localparam logic [31:0] BASE = 32'h40000000;

   logic        clk;
   logic        reset;
   logic        rd;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [7:0]  led;
   logic [7:0]  switch;
   logic [11:0] digi;
   logic        irq;
   logic        uartTx;

   int checkCount = 0;
   int errCount   = 0;

   mmio_timer_uart #(.BAUD_DIV(BD), .BASE(BASE)) dut (
      .clk    (clk),
      .reset  (reset),
      .rd     (rd),
      .wr     (wr),
      .addr   (addr),
      .wdata  (wdata),
      .rdata  (rdata),
      .led    (led),
      .switch (switch),
      .digi   (digi),
      .irq    (irq),
      .uart_tx(uartTx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state: register contents plus "frame in flight for mCnt cycles".
   bit          modelValid = 1'b0;
   logic [31:0] mTH, mTL;
   logic        mTen, mIen, mSt, mIrq;
   logic [7:0]  mLed, mTxd;
   logic [11:0] mDigi;
   bit          mActive;
   int          mCnt;
   logic        mDone;

   function automatic bit isHit(input logic [31:0] a);
      return (a & 32'hFFFFFFE0) == BASE;
   endfunction

   function automatic logic expTx();
      int k;
      if (!mActive) return 1'b1;
      k = mCnt / BD;
      if (k == 0) return 1'b0;
      if (k <= 8) return mTxd[k-1];
      return 1'b1;
   endfunction

   function automatic logic [31:0] expRdata();
      if (!(rd && isHit(addr))) return 32'd0;
      case (addr[4:2])
         3'd0:    return mTH;
         3'd1:    return mTL;
         3'd2:    return {29'd0, mSt, mIen, mTen};
         3'd3:    return {24'd0, mLed};
         3'd4:    return {24'd0, switch};
         3'd5:    return {20'd0, mDigi};
         3'd6:    return {24'd0, mTxd};
         default: return {30'd0, mDone, mActive};
      endcase
   endfunction

   always @(posedge clk) begin
      logic [31:0] newTH, newTL;
      logic        newTen, newIen, newSt, ovf, w, wasActive;
      if (!reset) begin
         mTH = 0; mTL = 0; mTen = 0; mIen = 0; mSt = 0; mIrq = 0;
         mLed = 0; mDigi = 0; mTxd = 0; mActive = 0; mCnt = 0; mDone = 0;
         modelValid = 1'b1;
      end else if (modelValid) begin
         w      = wr && isHit(addr);
         ovf    = mTen && (mTL == 32'hFFFFFFFF);
         newTL  = mTen ? (ovf ? mTH : mTL + 32'd1) : mTL;
         newSt  = mSt | (ovf & mIen);
         newTH  = mTH;
         newTen = mTen;
         newIen = mIen;
         if (w) begin
            case (addr[4:2])
               3'd0: newTH = wdata;
               3'd1: newTL = wdata;
               3'd2: begin
                  newTen = wdata[0];
                  newIen = wdata[1];
                  if (!wdata[2]) newSt = 1'b0;
               end
               3'd3: mLed  = wdata[7:0];
               3'd5: mDigi = wdata[11:0];
               default: ;
            endcase
         end
         mTH = newTH; mTL = newTL; mTen = newTen; mIen = newIen; mSt = newSt;
         mIrq = mIen & mSt;
         wasActive = mActive;
         if (w && addr[4:2] == 3'd7 && wdata[1]) mDone = 1'b0;
         if (mActive) begin
            mCnt++;
            if (mCnt == 10 * BD) begin
               mActive = 1'b0;
               mDone   = 1'b1;
            end
         end
         if (w && addr[4:2] == 3'd6 && !wasActive) begin
            mTxd    = wdata[7:0];
            mActive = 1'b1;
            mCnt    = 0;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (modelValid) begin
         checkOutput("led", {24'd0, led}, {24'd0, mLed});
         checkOutput("digi", {20'd0, digi}, {20'd0, mDigi});
         checkOutput("irq", {31'd0, irq}, {31'd0, mIrq});
         checkOutput("uart_tx", {31'd0, uartTx}, {31'd0, expTx()});
         checkOutput("rdata", rdata, expRdata());
      end
   end

   task automatic applyStimulus(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
      wr = w; rd = r; addr = a; wdata = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      wr = 0; rd = 0; addr = 0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic cpuWrite(input logic [31:0] a, input logic [31:0] d);
      applyStimulus(1'b1, 1'b0, a, d);
      wr = 0; addr = 0;
   endtask

   task automatic cpuRead(input logic [31:0] a, output logic [31:0] d);
      wr = 0; rd = 1; addr = a;
      @(negedge clk);
      d = rdata;
      @(posedge clk);
      #1;
      rd = 0; addr = 0;
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] v;
      logic [9:0]  frame;
      logic [2:0]  off;
      reset = 0; rd = 0; wr = 0; addr = 0; wdata = 0; switch = 0;

      // Reset state
      idle(2);
      checkOutput("reset led", {24'd0, led}, 32'd0);
      checkOutput("reset digi", {20'd0, digi}, 32'd0);
      checkOutput("reset irq", {31'd0, irq}, 32'd0);
      checkOutput("reset uart_tx", {31'd0, uartTx}, 32'd1);
      cpuRead(32'h40000008, v);
      checkOutput("reset tcon", v, 32'd0);
      reset = 1;

      // Timer overflow and interrupt clear
      cpuWrite(32'h40000000, 32'hFFFFFFFC);
      cpuWrite(32'h40000004, 32'hFFFFFFFE);
      cpuWrite(32'h40000008, 32'd3);
      idle(1);
      cpuRead(32'h40000004, v);
      checkOutput("tl pre-ovf", v, 32'hFFFFFFFF);
      checkOutput("irq after ovf", {31'd0, irq}, 32'd1);
      cpuRead(32'h40000004, v);
      checkOutput("tl reload", v, 32'hFFFFFFFC);
      cpuRead(32'h40000008, v);
      checkOutput("tcon status", v, 32'd7);
      cpuWrite(32'h40000008, 32'd3);
      checkOutput("irq cleared", {31'd0, irq}, 32'd0);
      cpuWrite(32'h40000008, 32'd0);
      cpuRead(32'h40000008, v);
      checkOutput("tcon off", v, 32'd0);
      cpuRead(32'h40000004, v);
      checkOutput("tl held", v, 32'hFFFFFFFC);
      cpuWrite(32'h40000004, 32'hFFFFFFFF);
      cpuWrite(32'h40000008, 32'd3);
      cpuWrite(32'h40000008, 32'd7);
      checkOutput("irq set despite write", {31'd0, irq}, 32'd1);
      cpuWrite(32'h40000008, 32'd0);

      // Simple registers
      switch = 8'hA5;
      cpuRead(32'h40000010, v);
      checkOutput("switch read", v, 32'h000000A5);
      cpuWrite(32'h40000014, 32'h1234);
      checkOutput("digi", {20'd0, digi}, 32'h234);
      cpuWrite(32'h4000000C, 32'hFF);
      checkOutput("led", {24'd0, led}, 32'hFF);
      rd = 0; addr = 32'h40000010;
      @(negedge clk);
      checkOutput("rdata rd=0", rdata, 32'd0);
      @(posedge clk);
      #1;

      // UART frame with a write attempted while busy
      frame = {1'b1, 8'h5A, 1'b0};
      cpuWrite(32'h40000018, 32'h5A);
      fork
         begin
            for (int k = 0; k < 10 * BD; k++) begin
               @(negedge clk);
               checkOutput("frame bit", {31'd0, uartTx}, {31'd0, frame[k/BD]});
            end
         end
         begin
            logic [31:0] t;
            idle(5);
            cpuRead(32'h4000001C, t);
            checkOutput("tx busy", t, 32'd1);
            idle(3);
            cpuWrite(32'h40000018, 32'h33);
            cpuRead(32'h40000018, t);
            checkOutput("txd readback busy", t, 32'h5A);
         end
      join
      @(posedge clk);
      #1;
      cpuRead(32'h4000001C, v);
      checkOutput("tx done", v, 32'd2);
      cpuWrite(32'h4000001C, 32'd2);
      cpuRead(32'h4000001C, v);
      checkOutput("tx done cleared", v, 32'd0);

      // Reset during DATA, then a clean frame
      cpuWrite(32'h40000018, 32'hC3);
      idle(13);
      checkOutput("tx data bit2", {31'd0, uartTx}, 32'd0);
      reset = 0;
      @(posedge clk);
      #1;
      checkOutput("tx after reset", {31'd0, uartTx}, 32'd1);
      reset = 1;
      cpuRead(32'h4000001C, v);
      checkOutput("ucon after reset", v, 32'd0);
      cpuWrite(32'h40000018, 32'h96);
      idle(42);
      cpuRead(32'h40000018, v);
      checkOutput("txd new frame", v, 32'h96);
      cpuRead(32'h4000001C, v);
      checkOutput("new frame done", v, 32'd2);

      // Random traffic against the model
      for (int i = 0; i < 2000; i++) begin
         reset  = ($urandom_range(0, 399) != 0);
         switch = 8'($urandom);
         off    = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) v = $urandom;
         else v = BASE | (32'(off) << 2) | 32'($urandom_range(0, 3));
         wdata = $urandom;
         if ((off == 3'd0 || off == 3'd1) && $urandom_range(0, 1) == 1)
            wdata = 32'hFFFFFFFF - 32'($urandom_range(0, 6));
         applyStimulus(($urandom_range(0, 99) < 30), 1'($urandom_range(0, 1)), v, wdata);
      end
      reset = 1;
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errCount);
      $finish;
   end

endmodule
